// File: rtl/memory_ram_pkg.sv
// Shared types and helpers for the memory_ram_ctrl block: FSM state encoding and lane-count helper.
package memory_ram_pkg;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_e;

    function automatic int nlanes(input int data_width, input int lane_width);
        return data_width / lane_width;
    endfunction

endpackage

// File: rtl/memory_ram_core.sv
// Storage array with per-lane write enables and a registered read port; no reset, no control.
// Latency: read data valid one cycle after re; writes land at the clock edge.
module memory_ram_core #(
    parameter int ADD_WIDTH  = 6,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 64,
    parameter int LANE_WIDTH = 4,
    parameter int NLANES     = 2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADD_WIDTH-1:0]  addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [NLANES-1:0]     be,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NLANES; i++) begin
                if (be[i]) begin
                    mem[addr][i*LANE_WIDTH +: LANE_WIDTH] <= wdata[i*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/memory_ram_ctrl.sv
// Single-port RAM controller: init sweep FSM, range check, optional output register, sticky error.
// Read latency 1 (OUT_REG=0) or 2 (OUT_REG=1); req_ready low during sweep, responses never stall.
module memory_ram_ctrl
    import memory_ram_pkg::*;
#(
    parameter int                    ADD_WIDTH  = 6,
    parameter int                    DATA_WIDTH = 8,
    parameter int                    DEPTH      = 64,
    parameter int                    LANE_WIDTH = 4,
    parameter int                    OUT_REG    = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           req_valid,
    output logic                                           req_ready,
    input  logic                                           req_wr,
    input  logic [ADD_WIDTH-1:0]                           req_addr,
    input  logic [DATA_WIDTH-1:0]                          req_wdata,
    input  logic [nlanes(DATA_WIDTH, LANE_WIDTH)-1:0]      req_be,
    output logic                                           rsp_valid,
    output logic [DATA_WIDTH-1:0]                          rsp_data,
    output logic                                           rsp_err,
    output logic                                           err_sticky,
    input  logic                                           init_start,
    output logic                                           init_busy
);

    localparam int                 NLANES    = nlanes(DATA_WIDTH, LANE_WIDTH);
    localparam logic [ADD_WIDTH:0] DEPTH_LIM = (ADD_WIDTH+1)'(DEPTH);
    localparam logic [ADD_WIDTH-1:0] LAST    = ADD_WIDTH'(DEPTH - 1);

    state_e                state_q, state_d;
    logic [ADD_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  in_range, accept;
    logic                  mem_we, mem_re;
    logic [ADD_WIDTH-1:0]  mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata, mem_rdata;
    logic [NLANES-1:0]     mem_be;
    logic                  vld1, err1;
    logic [DATA_WIDTH-1:0] data1;

    assign in_range = {1'b0, req_addr} < DEPTH_LIM;
    assign accept   = req_valid && req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The single RAM port is owned by the sweep in INIT and by the requester in READY.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_ready = 1'b0;
        init_busy = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = req_addr;
        mem_wdata = req_wdata;
        mem_be    = req_be;
        case (state_q)
            ST_INIT: begin
                init_busy = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = cnt_q;
                mem_wdata = INIT_VALUE;
                mem_be    = '1;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end
            end
            ST_READY: begin
                req_ready = 1'b1;
                mem_we    = req_valid && req_wr && in_range;
                mem_re    = req_valid && !req_wr && in_range;
                if (init_start) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    memory_ram_core #(
        .ADD_WIDTH (ADD_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .LANE_WIDTH(LANE_WIDTH),
        .NLANES    (NLANES)
    ) u_core (
        .clk  (clk),
        .we   (mem_we),
        .re   (mem_re),
        .addr (mem_addr),
        .wdata(mem_wdata),
        .be   (mem_be),
        .rdata(mem_rdata)
    );

    // Sweep start clears the sticky flag even if an out-of-range request rides along.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld1       <= 1'b0;
            err1       <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            vld1 <= accept && !req_wr;
            err1 <= accept && !req_wr && !in_range;
            if (state_q == ST_READY && init_start) begin
                err_sticky <= 1'b0;
            end else if (accept && !in_range) begin
                err_sticky <= 1'b1;
            end
        end
    end

    assign data1 = (vld1 && !err1) ? mem_rdata : '0;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  vld2, err2;
            logic [DATA_WIDTH-1:0] data2;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld2  <= 1'b0;
                    err2  <= 1'b0;
                    data2 <= '0;
                end else begin
                    vld2  <= vld1;
                    err2  <= err1;
                    data2 <= data1;
                end
            end
            assign rsp_valid = vld2;
            assign rsp_err   = err2;
            assign rsp_data  = data2;
        end else begin : g_no_out_reg
            assign rsp_valid = vld1;
            assign rsp_err   = err1;
            assign rsp_data  = data1;
        end
    endgenerate

endmodule

// File: tb/tb_memory_ram_ctrl.sv
// Directed bench: three controllers (latency 1, latency 2, DEPTH=48) share one stimulus stream.
module tb_memory_ram_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_wr, init_start;
    logic [5:0] req_addr;
    logic [7:0] req_wdata;
    logic [1:0] req_be;

    logic       rdy [3];
    logic       busy[3];
    logic       vld [3];
    logic       err [3];
    logic       stk [3];
    logic [7:0] dat [3];

    int vectors = 0;
    int errs    = 0;
    int n, n2;

    always #5 clk = ~clk;

    memory_ram_ctrl #(.OUT_REG(0)) u0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[0]), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(vld[0]),
        .rsp_data(dat[0]), .rsp_err(err[0]), .err_sticky(stk[0]), .init_start(init_start),
        .init_busy(busy[0])
    );

    memory_ram_ctrl #(.OUT_REG(1)) u1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[1]), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(vld[1]),
        .rsp_data(dat[1]), .rsp_err(err[1]), .err_sticky(stk[1]), .init_start(init_start),
        .init_busy(busy[1])
    );

    memory_ram_ctrl #(.DEPTH(48)) u2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[2]), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(vld[2]),
        .rsp_data(dat[2]), .rsp_err(err[2]), .err_sticky(stk[2]), .init_start(init_start),
        .init_busy(busy[2])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic wr, input logic [5:0] addr, input logic [7:0] wd,
                          input logic [1:0] be, input logic start);
        req_valid  = 1'b1;
        req_wr     = wr;
        req_addr   = addr;
        req_wdata  = wd;
        req_be     = be;
        init_start = start;
        tick();
        req_valid  = 1'b0;
        req_wr     = 1'b0;
        init_start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; init_start = 1'b0;
        req_addr = '0; req_wdata = '0; req_be = '0;
        repeat (3) tick();

        check("rst_req_ready",  rdy[0],  0);
        check("rst_init_busy",  busy[0], 1);
        check("rst_rsp_valid",  vld[0],  0);
        check("rst_rsp_data",   dat[0],  0);
        check("rst_rsp_err",    err[0],  0);
        check("rst_err_sticky", stk[0],  0);
        check("rst_rsp_data_or", dat[1], 0);

        // Sweep length after reset release
        rst_n = 1'b1;
        n = 0; n2 = 0;
        while (!rdy[0] && n < 200) begin
            tick();
            n++;
            if (rdy[2] && n2 == 0) n2 = n;
        end
        check("ready_after_d64", n, 64);
        check("ready_after_d48", n2, 48);
        check("busy_low_ready", busy[0], 0);

        // Read of top address after sweep; latency 1 vs 2
        do_req(0, 6'h3F, 8'h00, 2'b00, 0);
        check("rd3f_vld_l1",  vld[0], 1);
        check("rd3f_dat_l1",  dat[0], 8'h00);
        check("rd3f_err_l1",  err[0], 0);
        check("rd3f_vld_l2_early", vld[1], 0);
        tick();
        check("rd3f_vld_l2",  vld[1], 1);
        check("rd3f_dat_l2",  dat[1], 8'h00);
        check("rd3f_vld_l1_once", vld[0], 0);

        // Lane enables: A5 full, then 3C low lane only, then a be=0 no-op
        do_req(1, 6'd5, 8'hA5, 2'b11, 0);
        do_req(1, 6'd5, 8'h3C, 2'b01, 0);
        do_req(1, 6'd5, 8'hFF, 2'b00, 0);
        do_req(0, 6'd5, 8'h00, 2'b00, 0);
        check("lane_merge_vld", vld[0], 1);
        check("lane_merge_dat", dat[0], 8'hAC);

        // Write then read next cycle
        do_req(1, 6'd9, 8'h77, 2'b11, 0);
        do_req(0, 6'd9, 8'h00, 2'b00, 0);
        check("wr_rd_dat_l1", dat[0], 8'h77);
        check("wr_rd_vld_l2_early", vld[1], 0);
        tick();
        check("wr_rd_vld_l2", vld[1], 1);
        check("wr_rd_dat_l2", dat[1], 8'h77);

        // Back-to-back reads keep order
        do_req(0, 6'd5, 8'h00, 2'b00, 0);
        check("b2b_first_l1", dat[0], 8'hAC);
        do_req(0, 6'd9, 8'h00, 2'b00, 0);
        check("b2b_second_l1", dat[0], 8'h77);
        check("b2b_first_l2", dat[1], 8'hAC);
        tick();
        check("b2b_second_l2", dat[1], 8'h77);
        check("b2b_l1_idle", vld[0], 0);

        // Out-of-range on DEPTH=48 instance (in range for the others)
        do_req(1, 6'd50, 8'hEE, 2'b11, 0);
        check("oor_wr_sticky", stk[2], 1);
        check("inr_wr_no_sticky", stk[0], 0);
        do_req(0, 6'd50, 8'h00, 2'b00, 0);
        check("oor_rd_vld", vld[2], 1);
        check("oor_rd_err", err[2], 1);
        check("oor_rd_dat", dat[2], 8'h00);
        check("inr_rd_err", err[0], 0);
        check("inr_rd_dat", dat[0], 8'hEE);
        do_req(0, 6'd2, 8'h00, 2'b00, 0);
        check("oor_alias_dat", dat[2], 8'h00);
        check("oor_alias_err", err[2], 0);
        do_req(0, 6'd47, 8'h00, 2'b00, 0);
        check("oor_top_dat", dat[2], 8'h00);
        check("sticky_holds", stk[2], 1);

        // Re-init with a read riding along; init_start mid-sweep is ignored
        do_req(1, 6'd3, 8'h55, 2'b11, 0);
        do_req(0, 6'd3, 8'h00, 2'b00, 1);
        check("reinit_rd_dat", dat[0], 8'h55);
        check("reinit_busy", busy[0], 1);
        check("reinit_ready_low", rdy[0], 0);
        check("reinit_sticky_clr", stk[2], 0);
        n = 1;
        tick();
        check("drain_into_init_vld", vld[1], 1);
        check("drain_into_init_dat", dat[1], 8'h55);
        while (busy[0] && n < 200) begin
            init_start = (n == 10);
            n++;
            tick();
        end
        init_start = 1'b0;
        check("reinit_busy_cycles", n, 64);
        do_req(0, 6'd3, 8'h00, 2'b00, 0);
        check("reinit_cleared_l1", dat[0], 8'h00);
        tick();
        check("reinit_cleared_l2_vld", vld[1], 1);
        check("reinit_cleared_l2", dat[1], 8'h00);

        // Pending response discarded by reset
        do_req(0, 6'd9, 8'h00, 2'b00, 0);
        rst_n = 1'b0;
        #1;
        check("rst_kills_rsp_l1", vld[0], 0);
        tick();
        check("rst_kills_rsp_l2", vld[1], 0);

        // Reset at sweep address 20 restarts the full sweep
        rst_n = 1'b1;
        repeat (20) tick();
        check("mid_sweep_busy", busy[0], 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n = 0;
        while (!rdy[0] && n < 200) begin
            tick();
            n++;
        end
        check("mid_sweep_restart", n, 64);
        do_req(0, 6'd9, 8'h00, 2'b00, 0);
        check("post_sweep_dat", dat[0], 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/memory_ram_ctrl.md
# memory_ram_ctrl

Parametrised single-port synchronous RAM with a valid/ready request port, per-lane write enables, selectable read latency, out-of-range address detection and a hardware initialisation sweep. It replaces the bare read/write memory in designs that need deterministic contents after reset and a handshake-controlled access port. It sits between a requesting master (counter, divider control logic or host interface) and on-chip block RAM.

## Interface
- ADD_WIDTH, 6, address width; DEPTH must be ≤ 2**ADD_WIDTH
- DATA_WIDTH, 8, word width; must be a multiple of LANE_WIDTH
- DEPTH, 64, number of words
- LANE_WIDTH, 4, bits per write-enable lane; NLANES = DATA_WIDTH/LANE_WIDTH
- OUT_REG, 0, 0 = read latency 1, 1 = read latency 2 (extra output register)
- INIT_VALUE, 0, word written to every location by the init sweep

Ports:
- clk  in  1  rising-edge clock, single clock domain
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  ADD_WIDTH  word address
- req_wdata  in  DATA_WIDTH  write data
- req_be  in  NLANES  lane write enables (ignored on reads)
- rsp_valid  out  1  one-cycle read-data strobe, no backpressure
- rsp_data  out  DATA_WIDTH  read data, valid with rsp_valid
- rsp_err  out  1  read address ≥ DEPTH, valid with rsp_valid
- err_sticky  out  1  set by any accepted out-of-range request
- init_start  in  1  request a re-initialisation sweep
- init_busy  out  1  sweep in progress

## Operation
- States: INIT, READY. Reset enters INIT with sweep counter 0.
- INIT: each cycle writes INIT_VALUE to mem[counter]; counter increments; after writing DEPTH-1, next state READY. req_ready = 0, init_busy = 1 throughout.
- READY: req_ready = 1, init_busy = 0. init_start = 1 → counter cleared, INIT next cycle, err_sticky cleared.
- init_start in INIT is ignored (sweep not restarted).
- Accepted write, addr < DEPTH: for each lane i with req_be[i] = 1, mem[addr] lane i ← req_wdata lane i; other lanes unchanged. req_be = 0 is a legal no-op.
- Accepted read, addr < DEPTH: rsp_data = mem[addr], rsp_err = 0.
- addr ≥ DEPTH: write dropped; read returns rsp_data = 0, rsp_err = 1; err_sticky ← 1 in both cases.
- Request and init_start in the same READY cycle: the request is executed, sweep starts next cycle.
- Outstanding read responses always drain, including into INIT.
- Reset mid-sweep or mid-read: sweep restarts from address 0, pending responses discarded.

## Timing
- Reset values: req_ready 0, init_busy 1, rsp_valid 0, rsp_data 0, rsp_err 0, err_sticky 0.
- First req_ready = 1 is DEPTH cycles after first clk edge with rst_n high.
- Read accepted at edge N: rsp_valid high after edge N+1 (OUT_REG=0) or N+2 (OUT_REG=1), for exactly one cycle.
- Back-to-back reads: one response per cycle, in request order.
- Write at edge N then read same address at edge N+1: returns the newly written data.
- Throughput: one request per cycle in READY.

## Structure
- Package memory_ram_pkg: state enum (ST_INIT, ST_READY); helper function computing NLANES.
- Sub-module memory_ram_core: storage array with per-lane write enable and registered read; no control logic. memory_ram_ctrl holds FSM, sweep counter, address check, OUT_REG stage and error flag.

## Test plan
- Reset release, DEPTH=64 → req_ready rises after 64 cycles; read of addr 0x3F returns 0x00, rsp_err 0.
- Write 0xA5 to addr 5 with be=2'b11, then write 0x3C with be=2'b01 → read addr 5 returns 0xAC.
- Write 0x77 to addr 9 at cycle N, read addr 9 at N+1 → 0x77; repeat with OUT_REG=1 and confirm 2-cycle latency.
- DEPTH=48, read addr 50 → rsp_data 0, rsp_err 1, err_sticky 1; write addr 50 leaves all locations unchanged.
- Write 0x55 to addr 3, pulse init_start together with a read of addr 3 → read returns 0x55, init_busy for 64 cycles, err_sticky cleared, re-read returns 0x00.
- Assert rst_n low at sweep address 20 → sweep restarts at 0, req_ready after a full DEPTH cycles.
